float_result_collector: RTL

Collects results from `N_LANES` parallel variable-latency float units, such as discriminant or arithmetic workers fed by a round-robin distributor. It returns them to the consumer strictly in issue order. The distributor reports each dispatch on the issue port. Lanes return results in any order, and the collector holds them until their turn. It sits at the output end of a distribute/compute/collect pipeline and provides a valid/ready handshake toward downstream logic.

---
 rtl/float_result_collector.sv | 131 +++++++++++++
 1 files changed

// File: rtl/float_result_collector.sv
// float_result_collector
// Gathers results from N_LANES variable-latency float workers and hands them
// to the consumer in the order the distributor issued them. An order FIFO
// records issued lane indices; per-lane holding registers park early results
// until their lane reaches the FIFO head.
module float_result_collector #(
  parameter int FLEN    = 64,
  parameter int N_LANES = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_vld,
  input  logic [$clog2(N_LANES)-1:0]   issue_lane,
  output logic                         issue_rdy,
  input  logic [N_LANES-1:0]           lane_vld,
  input  logic [N_LANES*FLEN-1:0]      lane_res,
  input  logic [N_LANES-1:0]           lane_err,
  output logic                         res_vld,
  input  logic                         res_rdy,
  output logic [FLEN-1:0]              res,
  output logic                         err,
  output logic [N_LANES-1:0]           lane_busy,
  output logic                         protocol_err
);

  localparam int LANE_W = $clog2(N_LANES);
  localparam int CNT_W  = $clog2(N_LANES + 1);
  localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(N_LANES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(N_LANES);
  localparam logic [LANE_W:0]   LANE_LIM = (LANE_W + 1)'(N_LANES);

  // Order FIFO of issued lane indices
  logic [LANE_W-1:0] fifo_q [N_LANES];
  logic [LANE_W-1:0] rd_ptr;
  logic [LANE_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  count;

  // Per-lane tracking and result parking
  logic [N_LANES-1:0] outstanding;
  logic [N_LANES-1:0] held;
  logic [FLEN-1:0]    hold_res [N_LANES];
  logic               hold_err [N_LANES];

  logic               fifo_full;
  logic               fifo_empty;
  logic               issue_lane_ok;
  logic [LANE_W-1:0]  head;
  logic               push;
  logic               pop;
  logic [N_LANES-1:0] capture;
  logic               illegal;
  logic [N_LANES-1:0] issue_mask;
  logic [N_LANES-1:0] pop_mask;

  assign fifo_full     = (count == FULL_CNT);
  assign fifo_empty    = (count == '0);
  // Indices past the last lane (non power-of-two lane counts) are never ready.
  assign issue_lane_ok = ({1'b0, issue_lane} < LANE_LIM);
  assign head          = fifo_q[rd_ptr];

  assign lane_busy = outstanding;
  assign issue_rdy = !fifo_full && issue_lane_ok && !outstanding[issue_lane];
  assign res_vld   = !fifo_empty && held[head];
  assign res       = hold_res[head];
  assign err       = hold_err[head];

  assign push = issue_vld && issue_rdy;
  assign pop  = res_vld && res_rdy;

  // A strobe is only accepted on a lane that owes a result and has none parked.
  assign capture = lane_vld & outstanding & ~held;
  assign illegal = |(lane_vld & ~(outstanding & ~held));

  // Decode the issued lane and the popped head lane into one-hot masks
  always_comb begin
    issue_mask = '0;
    pop_mask   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (push && (issue_lane == LANE_W'(i))) issue_mask[i] = 1'b1;
      if (pop && (head == LANE_W'(i)))        pop_mask[i]   = 1'b1;
    end
  end

  // Order FIFO, lane bookkeeping and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      outstanding  <= '0;
      held         <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < N_LANES; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= issue_lane;
        wr_ptr         <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Pop lane can never be the issue lane in the same cycle (it is busy).
      outstanding <= (outstanding & ~pop_mask) | issue_mask;
      held        <= (held & ~pop_mask) | capture;
      if (illegal) protocol_err <= 1'b1;
    end
  end

  // Park each accepted lane result until its turn at the FIFO head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        hold_res[i] <= '0;
        hold_err[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (capture[i]) begin
          hold_res[i] <= lane_res[i*FLEN +: FLEN];
          hold_err[i] <= lane_err[i];
        end
      end
    end
  end

endmodule
